// File: rtl/pwm_driver.sv
// Complementary dead-time-protected PWM pair for the actuator half-bridge.
// Duty is double-buffered (pending -> active at period boundaries); a prescaler sets the tick rate.
module pwm_driver #(
    parameter int DEAD_TIME = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] duty,
    input  logic       duty_valid,
    input  logic [7:0] prescale,
    output logic       duty_ack,
    output logic       period_start,
    output logic       pwm_hi,
    output logic       pwm_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [7:0] DT_M1   = 8'(DEAD_TIME - 1);
    localparam logic [7:0] CNT_MAX = 8'd254;

    state_t     state_q, state_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] active_q, active_d;
    logic       ps_d;
    logic       tick_s;
    logic       raw_s;
    logic       en_rise_s;

    // Using >= means a prescale decrease below the current pre_cnt still ticks at once.
    assign tick_s    = (pre_cnt_q >= prescale);
    assign raw_s     = (cnt_q < active_q);
    assign en_rise_s = enable && (state_q == IDLE);

    // Pending duty capture, prescaler, period counter and active-duty reload.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        pre_cnt_d = pre_cnt_q;
        active_d  = active_q;
        ps_d      = 1'b0;
        if (duty_valid) begin
            pending_d = duty;
        end else begin
            pending_d = pending_q;
        end
        if (!enable) begin
            cnt_d     = 8'd0;
            pre_cnt_d = 8'd0;
        end else if (en_rise_s) begin
            cnt_d     = 8'd0;
            pre_cnt_d = 8'd0;
            active_d  = pending_q;
            ps_d      = 1'b1;
        end else if (tick_s) begin
            pre_cnt_d = 8'd0;
            if (cnt_q == CNT_MAX) begin
                cnt_d    = 8'd0;
                active_d = pending_q;
                ps_d     = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
        end
    end

    // Output FSM: every handover passes through DEAD; raw is re-sampled when DEAD expires.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!enable) begin
            state_d = IDLE;
            dcnt_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    dcnt_d  = DT_M1;
                end
                HI: begin
                    if (!raw_s) begin
                        state_d = DEAD;
                        dcnt_d  = DT_M1;
                    end else begin
                        state_d = HI;
                    end
                end
                LO: begin
                    if (raw_s) begin
                        state_d = DEAD;
                        dcnt_d  = DT_M1;
                    end else begin
                        state_d = LO;
                    end
                end
                DEAD: begin
                    if (dcnt_q == 8'd0) begin
                        state_d = raw_s ? HI : LO;
                    end else begin
                        dcnt_d = dcnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dcnt_d  = 8'd0;
                end
            endcase
        end
    end

    // State and datapath registers; gate drives decode the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dcnt_q       <= 8'd0;
            cnt_q        <= 8'd0;
            pre_cnt_q    <= 8'd0;
            pending_q    <= 8'd0;
            active_q     <= 8'd0;
            duty_ack     <= 1'b0;
            period_start <= 1'b0;
            pwm_hi       <= 1'b0;
            pwm_lo       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            cnt_q        <= cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            duty_ack     <= duty_valid;
            period_start <= ps_d;
            pwm_hi       <= (state_d == HI);
            pwm_lo       <= (state_d == LO);
        end
    end

endmodule

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver: period length, pulse widths, dead bands, double buffering,
// prescaler, enable drop and asynchronous reset, with hand-computed expectations.
module tb_pwm_driver;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] duty;
    logic       duty_valid;
    logic [7:0] prescale;
    logic       duty_ack;
    logic       period_start;
    logic       pwm_hi;
    logic       pwm_lo;

    int total;
    int bad;
    int ovl_cnt;
    int viol_cnt;
    int lowrun;
    logic prev_hi;
    logic prev_lo;

    pwm_driver #(.DEAD_TIME(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .prescale     (prescale),
        .duty_ack     (duty_ack),
        .period_start (period_start),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Overlap and dead-band watchdog, sampled once per cycle on the falling edge.
    initial begin
        ovl_cnt  = 0;
        viol_cnt = 0;
        lowrun   = 100;
        prev_hi  = 1'b0;
        prev_lo  = 1'b0;
    end
    always @(negedge clk) begin
        if (pwm_hi && pwm_lo) ovl_cnt++;
        if ((pwm_hi && !prev_hi) || (pwm_lo && !prev_lo)) begin
            if (lowrun < 4) viol_cnt++;
        end
        lowrun  = (!pwm_hi && !pwm_lo) ? lowrun + 1 : 0;
        prev_hi = pwm_hi;
        prev_lo = pwm_lo;
    end

    // Accumulate from the current sample up to (not including) the next period_start sample.
    task automatic measure(output int len, output int hi, output int lo, output int gap);
        len = 0; hi = 0; lo = 0; gap = 0;
        do begin
            if (pwm_hi) hi++;
            if (pwm_lo) lo++;
            if (!pwm_hi && !pwm_lo) gap++;
            len++;
            @(negedge clk);
        end while (!period_start && len < 5000);
        if (len >= 5000) check("period_timeout", len, 0);
    endtask

    task automatic strobe(input logic [7:0] d);
        duty       = d;
        duty_valid = 1'b1;
        @(negedge clk);
        check("ack", int'(duty_ack), 1);
        duty_valid = 1'b0;
    endtask

    int len, hi, lo, gap, n;

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        duty       = 8'd0;
        duty_valid = 1'b0;
        prescale   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", int'(pwm_hi), 0);
        check("rst_lo", int'(pwm_lo), 0);
        check("rst_ack", int'(duty_ack), 0);
        check("rst_ps", int'(period_start), 0);
        rst_n = 1'b1;
        @(negedge clk);

        strobe(8'd128);
        @(negedge clk);
        check("ack_single", int'(duty_ack), 0);
        check("idle_ps", int'(period_start), 0);

        enable = 1'b1;
        @(negedge clk);
        check("en_ps", int'(period_start), 1);
        measure(len, hi, lo, gap);
        check("p0_len", len, 255);
        check("p0_hi", hi, 125);
        check("p0_lo", lo, 122);
        check("p0_gap", gap, 8);
        measure(len, hi, lo, gap);
        check("p1_len", len, 255);
        check("p1_hi", hi, 124);
        check("p1_lo", lo, 123);
        check("p1_gap", gap, 8);

        // Mid-period duty change at cnt=10: current period stays at 128.
        repeat (10) @(negedge clk);
        strobe(8'd64);
        measure(len, hi, lo, gap);
        check("mid_rest_hi", hi, 118);
        check("mid_rest_len", len, 244);
        measure(len, hi, lo, gap);
        check("d64_hi", hi, 60);
        check("d64_lo", lo, 187);

        // Strobe sampled on the wrap edge itself: old pending (64) is reloaded.
        repeat (254) @(negedge clk);
        duty       = 8'd200;
        duty_valid = 1'b1;
        @(negedge clk);
        check("wrap_ps", int'(period_start), 1);
        check("wrap_ack", int'(duty_ack), 1);
        duty_valid = 1'b0;
        measure(len, hi, lo, gap);
        check("wrap_old_hi", hi, 60);
        measure(len, hi, lo, gap);
        check("d200_hi", hi, 196);
        check("d200_lo", lo, 51);

        strobe(8'd0);
        measure(len, hi, lo, gap);
        check("d0_rest_hi", hi, 196);
        measure(len, hi, lo, gap);
        check("d0_hi", hi, 0);
        check("d0_lo", lo, 255);
        check("d0_gap", gap, 0);

        strobe(8'd255);
        measure(len, hi, lo, gap);
        check("d255_rest_lo", lo, 254);
        measure(len, hi, lo, gap);
        check("d255a_hi", hi, 250);
        check("d255a_lo", lo, 1);
        check("d255a_gap", gap, 4);
        measure(len, hi, lo, gap);
        check("d255b_hi", hi, 255);
        check("d255b_gap", gap, 0);

        // Prescale 3: 1020-clk periods; first period inherits HI across the boundary.
        prescale = 8'd3;
        strobe(8'd128);
        measure(len, hi, lo, gap);
        measure(len, hi, lo, gap);
        check("ps3a_len", len, 1020);
        check("ps3a_hi", hi, 513);
        measure(len, hi, lo, gap);
        check("ps3b_len", len, 1020);
        check("ps3b_hi", hi, 508);
        check("ps3b_lo", lo, 504);
        check("ps3b_gap", gap, 8);

        // Drop enable while pwm_hi is asserted.
        n = 0;
        while (!pwm_hi && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("find_hi", int'(pwm_hi), 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_hi", int'(pwm_hi), 0);
        check("dis_lo", int'(pwm_lo), 0);
        prescale = 8'd0;
        enable   = 1'b1;
        @(negedge clk);
        check("reen_ps", int'(period_start), 1);
        gap = 0;
        repeat (4) begin
            if (!pwm_hi && !pwm_lo) gap++;
            @(negedge clk);
        end
        check("reen_gap", gap, 4);
        check("reen_hi", int'(pwm_hi), 1);
        check("reen_lo", int'(pwm_lo), 0);

        // Asynchronous reset mid-period, then restart with pending cleared to 0.
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_hi", int'(pwm_hi), 0);
        check("arst_lo", int'(pwm_lo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ps", int'(period_start), 1);
        gap = 0;
        repeat (4) begin
            if (!pwm_hi && !pwm_lo) gap++;
            @(negedge clk);
        end
        check("rel_gap", gap, 4);
        check("rel_lo", int'(pwm_lo), 1);
        check("rel_hi", int'(pwm_hi), 0);

        repeat (3) @(negedge clk);
        check("overlap", ovl_cnt, 0);
        check("deadband", viol_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
